// File: rtl/valu_elem_sequencer.sv
// rtl/valu_elem_sequencer.sv - streams one vector ALU op element by element through a scalar ALU
// Optional feature: define VALU_MASK_EN to add the per-element vmask input.
module valu_elem_sequencer #(
  parameter int ELEN   = 32,
  parameter int MAX_VL = 8,
  localparam int VLW   = $clog2(MAX_VL + 1),
  localparam int VLEN  = ELEN * MAX_VL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ready,
  input  logic [3:0]        op,
  input  logic [VLW-1:0]    vl,
  input  logic [VLEN-1:0]   vs1,
  input  logic [VLEN-1:0]   vs2,
`ifdef VALU_MASK_EN
  input  logic [MAX_VL-1:0] vmask,
`endif
  output logic [3:0]        alu_op,
  output logic [ELEN-1:0]   alu_inA,
  output logic [ELEN-1:0]   alu_inB,
  input  logic [ELEN-1:0]   alu_out,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic [VLEN-1:0]   vd,
  output logic [MAX_VL-1:0] zero_mask,
  output logic              ovf_flag,
  output logic              done
);

  // Element index width for addressing the MAX_VL-entry arrays.
  localparam int IW = (MAX_VL > 1) ? $clog2(MAX_VL) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  state_t            state_nx;
  logic [3:0]        op_q;
  logic [VLW-1:0]    vl_q;
  logic [VLW-1:0]    vl_eff;
  logic [VLW-1:0]    idx;
  logic [IW-1:0]     idx_s;
  logic              last_elem;
  logic              elem_act;
  logic              accept;
  logic [ELEN-1:0]   vs1_q [MAX_VL];
  logic [ELEN-1:0]   vs2_q [MAX_VL];
  logic [ELEN-1:0]   vd_q  [MAX_VL];
  logic [MAX_VL-1:0] zmask_q;
  logic              ovf_q;
`ifdef VALU_MASK_EN
  logic [MAX_VL-1:0] vmask_q;
`endif

  assign vl_eff    = (vl > VLW'(MAX_VL)) ? VLW'(MAX_VL) : vl;
  assign idx_s     = idx[IW-1:0];
  assign last_elem = (idx == (vl_q - VLW'(1)));
  assign accept    = (state == IDLE) && start;

`ifdef VALU_MASK_EN
  assign elem_act = vmask_q[idx_s];
`else
  assign elem_act = 1'b1;
`endif

  // State register; reset aborts any op in flight without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and handshake / ALU drive outputs.
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    done     = 1'b0;
    alu_op   = '0;
    alu_inA  = '0;
    alu_inB  = '0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_nx = (vl_eff == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        alu_op  = op_q;
        alu_inA = vs2_q[idx_s];
        alu_inB = vs1_q[idx_s];
        if (last_elem) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture at accept and per-element result write-back during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      vl_q    <= '0;
      idx     <= '0;
      zmask_q <= '0;
      ovf_q   <= 1'b0;
`ifdef VALU_MASK_EN
      vmask_q <= '0;
`endif
      for (int i = 0; i < MAX_VL; i++) begin
        vs1_q[i] <= '0;
        vs2_q[i] <= '0;
        vd_q[i]  <= '0;
      end
    end else if (accept) begin
      op_q  <= op;
      vl_q  <= vl_eff;
      idx   <= '0;
      ovf_q <= 1'b0;
`ifdef VALU_MASK_EN
      vmask_q <= vmask;
`endif
      for (int i = 0; i < MAX_VL; i++) begin
        vs1_q[i] <= vs1[i*ELEN +: ELEN];
        vs2_q[i] <= vs2[i*ELEN +: ELEN];
        // Only the active head of zero_mask is cleared; the tail is undisturbed.
        if (i < int'(vl_eff)) begin
          zmask_q[i] <= 1'b0;
        end
      end
    end else if (state == RUN) begin
      if (elem_act) begin
        vd_q[idx_s]    <= alu_out;
        zmask_q[idx_s] <= alu_zero;
        ovf_q          <= ovf_q | alu_overflow;
      end
      idx <= idx + VLW'(1);
    end
  end

  // Pack the element registers onto the flat destination vector.
  always_comb begin
    vd = '0;
    for (int i = 0; i < MAX_VL; i++) begin
      vd[i*ELEN +: ELEN] = vd_q[i];
    end
  end

  assign zero_mask = zmask_q;
  assign ovf_flag  = ovf_q;

endmodule

// File: tb/tb_valu_elem_sequencer.sv
// tb/tb_valu_elem_sequencer.sv - directed self-checking bench for valu_elem_sequencer
module tb_valu_elem_sequencer;

  localparam int ELEN   = 32;
  localparam int MAX_VL = 8;
  localparam int VLW    = 4;
  localparam int VLEN   = ELEN * MAX_VL;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_PASS = 4'hF;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              ready;
  logic [3:0]        op = '0;
  logic [VLW-1:0]    vl = '0;
  logic [VLEN-1:0]   vs1 = '0;
  logic [VLEN-1:0]   vs2 = '0;
  logic [MAX_VL-1:0] vmask = '1;
  logic [3:0]        alu_op;
  logic [ELEN-1:0]   alu_inA;
  logic [ELEN-1:0]   alu_inB;
  logic [ELEN-1:0]   alu_out;
  logic              alu_zero;
  logic              alu_overflow;
  logic [VLEN-1:0]   vd;
  logic [MAX_VL-1:0] zero_mask;
  logic              ovf_flag;
  logic              done;
  logic [ELEN:0]     wide;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  valu_elem_sequencer #(.ELEN(ELEN), .MAX_VL(MAX_VL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .op(op), .vl(vl), .vs1(vs1), .vs2(vs2),
`ifdef VALU_MASK_EN
    .vmask(vmask),
`endif
    .alu_op(alu_op), .alu_inA(alu_inA), .alu_inB(alu_inB),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .vd(vd), .zero_mask(zero_mask), .ovf_flag(ovf_flag), .done(done)
  );

  // Reference combinational ALU: overflow is unsigned carry (ADD) / borrow (SUB).
  always_comb begin
    wide         = '0;
    alu_out      = '0;
    alu_overflow = 1'b0;
    case (alu_op)
      OP_ADD: begin
        wide         = {1'b0, alu_inA} + {1'b0, alu_inB};
        alu_out      = wide[ELEN-1:0];
        alu_overflow = wide[ELEN];
      end
      OP_SUB: begin
        alu_out      = alu_inA - alu_inB;
        alu_overflow = (alu_inA < alu_inB);
      end
      OP_PASS: alu_out = alu_inA;
      default: alu_out = '0;
    endcase
  end
  assign alu_zero = (alu_out == '0);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [ELEN-1:0] el(input logic [VLEN-1:0] v, input int i);
    return v[i*ELEN +: ELEN];
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [VLW-1:0] l, input logic [MAX_VL-1:0] m,
                        output int lat);
    int w;
    w = 0;
    while (ready !== 1'b1 && w < 50) begin
      @(posedge clk); #1; w++;
    end
    op = o; vl = l; vmask = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset();
    #3;
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (vd !== '0) begin fails++; $display("FAIL reset_vd got %h want 0", vd); end
    tests++; if (zero_mask !== '0 || ovf_flag !== 1'b0) begin
      fails++; $display("FAIL reset_flags got zm=%b ovf=%b want 0 0", zero_mask, ovf_flag);
    end
    tests++; if (alu_op !== '0 || alu_inA !== '0 || alu_inB !== '0) begin
      fails++; $display("FAIL reset_alu got op=%h a=%h b=%h want 0", alu_op, alu_inA, alu_inB);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat;
    logic [ELEN-1:0] exp_e [4];
    exp_e = '{32'd2, 32'd3, 32'd0, 32'd0};
    vs2 = '0; vs1 = '0;
    vs2[0*ELEN +: ELEN] = 32'd1;          vs1[0*ELEN +: ELEN] = 32'd1;
    vs2[1*ELEN +: ELEN] = 32'd2;          vs1[1*ELEN +: ELEN] = 32'd1;
    vs2[2*ELEN +: ELEN] = 32'hFFFF_FFFF;  vs1[2*ELEN +: ELEN] = 32'd1;
    vs2[3*ELEN +: ELEN] = 32'd5;          vs1[3*ELEN +: ELEN] = 32'hFFFF_FFFB;
    run_op(OP_ADD, 4'd4, '1, lat);
    tests++; if (lat != 5) begin fails++; $display("FAIL add_latency got %0d want 5", lat); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (el(vd, i) !== exp_e[i]) begin
        fails++; $display("FAIL add_vd%0d got %h want %h", i, el(vd, i), exp_e[i]);
      end
    end
    tests++; if (vd[VLEN-1:4*ELEN] !== '0) begin fails++; $display("FAIL add_tail got %h want 0", vd[VLEN-1:4*ELEN]); end
    tests++; if (zero_mask !== 8'b0000_1100) begin fails++; $display("FAIL add_zmask got %b want 00001100", zero_mask); end
    tests++; if (ovf_flag !== 1'b1) begin fails++; $display("FAIL add_ovf got %b want 1", ovf_flag); end
    @(posedge clk); #1;
    tests++; if (done !== 1'b0 || ready !== 1'b1) begin
      fails++; $display("FAIL add_done_pulse got done=%b ready=%b want 0 1", done, ready);
    end
  endtask

  task automatic test_vl_zero();
    int lat;
    logic [VLEN-1:0] vd_s;
    logic [MAX_VL-1:0] zm_s;
    vd_s = vd; zm_s = zero_mask;
    vs2 = '1; vs1 = '1;
    run_op(OP_ADD, 4'd0, '1, lat);
    tests++; if (lat != 1) begin fails++; $display("FAIL vl0_latency got %0d want 1", lat); end
    tests++; if (vd !== vd_s) begin fails++; $display("FAIL vl0_vd got %h want %h", vd, vd_s); end
    tests++; if (zero_mask !== zm_s) begin fails++; $display("FAIL vl0_zmask got %b want %b", zero_mask, zm_s); end
    @(posedge clk); #1;
  endtask

  task automatic test_sub_ignore_start();
    int lat, ndone;
    lat = 0; ndone = 0;
    vs2 = '0; vs1 = '0;
    vs2[0*ELEN +: ELEN] = 32'd10; vs1[0*ELEN +: ELEN] = 32'd3;
    vs2[1*ELEN +: ELEN] = 32'd7;  vs1[1*ELEN +: ELEN] = 32'd7;
    vs2[2*ELEN +: ELEN] = 32'd9;  vs1[2*ELEN +: ELEN] = 32'd1;
    op = OP_SUB; vl = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL sub_ready_run got %b want 0", ready); end
    op = OP_ADD; vl = 4'd8;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 2; c < 16; c++) begin
      if (done === 1'b1) begin
        ndone++;
        if (lat == 0) lat = c;
      end
      @(posedge clk); #1;
    end
    tests++; if (lat != 3) begin fails++; $display("FAIL sub_latency got %0d want 3", lat); end
    tests++; if (ndone != 1) begin fails++; $display("FAIL sub_done_count got %0d want 1", ndone); end
    tests++; if (el(vd, 0) !== 32'd7 || el(vd, 1) !== 32'd0) begin
      fails++; $display("FAIL sub_vd got %h %h want 7 0", el(vd, 0), el(vd, 1));
    end
    tests++; if (el(vd, 2) !== 32'd0 || el(vd, 3) !== 32'd0) begin
      fails++; $display("FAIL sub_tail got %h %h want 0 0", el(vd, 2), el(vd, 3));
    end
    tests++; if (zero_mask !== 8'b0000_1110) begin fails++; $display("FAIL sub_zmask got %b want 00001110", zero_mask); end
  endtask

  task automatic test_ovf_clear();
    int lat;
    vs2 = '0; vs1 = '0;
    vs2[0 +: ELEN] = 32'hFFFF_FFFF; vs1[0 +: ELEN] = 32'hFFFF_FFFF;
    run_op(OP_ADD, 4'd1, '1, lat);
    tests++; if (el(vd, 0) !== 32'hFFFF_FFFE) begin fails++; $display("FAIL ovf_vd got %h want fffffffe", el(vd, 0)); end
    tests++; if (ovf_flag !== 1'b1) begin fails++; $display("FAIL ovf_set got %b want 1", ovf_flag); end
    vs2[0 +: ELEN] = 32'd1; vs1[0 +: ELEN] = 32'd2;
    run_op(OP_ADD, 4'd1, '1, lat);
    tests++; if (ovf_flag !== 1'b0 || el(vd, 0) !== 32'd3) begin
      fails++; $display("FAIL ovf_clear got ovf=%b vd0=%h want 0 3", ovf_flag, el(vd, 0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clamp();
    int lat;
    for (int i = 0; i < MAX_VL; i++) begin
      vs2[i*ELEN +: ELEN] = 32'(i);
      vs1[i*ELEN +: ELEN] = 32'd100;
    end
    run_op(OP_ADD, 4'd12, '1, lat);
    tests++; if (lat != 9) begin fails++; $display("FAIL clamp_latency got %0d want 9", lat); end
    for (int i = 0; i < MAX_VL; i++) begin
      tests++; if (el(vd, i) !== 32'(100 + i)) begin
        fails++; $display("FAIL clamp_vd%0d got %h want %h", i, el(vd, i), 32'(100 + i));
      end
    end
    tests++; if (zero_mask !== '0 || ovf_flag !== 1'b0) begin
      fails++; $display("FAIL clamp_flags got zm=%b ovf=%b want 0 0", zero_mask, ovf_flag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat, ndone;
    ndone = 0;
    for (int i = 0; i < MAX_VL; i++) begin
      vs2[i*ELEN +: ELEN] = 32'd50;
      vs1[i*ELEN +: ELEN] = 32'(i);
    end
    op = OP_ADD; vl = 4'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests++; if (ready !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL rstmid_state got ready=%b done=%b want 1 0", ready, done);
    end
    tests++; if (vd !== '0 || zero_mask !== '0) begin
      fails++; $display("FAIL rstmid_vd got vd=%h zm=%b want 0", vd, zero_mask);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    tests++; if (ndone != 0) begin fails++; $display("FAIL rstmid_no_done got %0d want 0", ndone); end
    vs2 = '0; vs1 = '0;
    vs2[0*ELEN +: ELEN] = 32'd4; vs1[0*ELEN +: ELEN] = 32'd5;
    vs2[1*ELEN +: ELEN] = 32'd0; vs1[1*ELEN +: ELEN] = 32'd0;
    vs2[2*ELEN +: ELEN] = 32'd8; vs1[2*ELEN +: ELEN] = 32'd8;
    run_op(OP_ADD, 4'd3, '1, lat);
    tests++; if (lat != 4) begin fails++; $display("FAIL rstmid_next_latency got %0d want 4", lat); end
    tests++; if (el(vd, 0) !== 32'd9 || el(vd, 1) !== 32'd0 || el(vd, 2) !== 32'd16) begin
      fails++; $display("FAIL rstmid_next_vd got %h %h %h want 9 0 10", el(vd, 0), el(vd, 1), el(vd, 2));
    end
    tests++; if (zero_mask !== 8'b0000_0010) begin fails++; $display("FAIL rstmid_next_zmask got %b want 00000010", zero_mask); end
    @(posedge clk); #1;
  endtask

`ifdef VALU_MASK_EN
  task automatic test_mask();
    int lat;
    vs2 = '0; vs1 = '0;
    vs2[0*ELEN +: ELEN] = 32'd10; vs2[1*ELEN +: ELEN] = 32'd20;
    vs2[2*ELEN +: ELEN] = 32'd30; vs2[3*ELEN +: ELEN] = 32'd40;
    run_op(OP_ADD, 4'd4, '1, lat);
    @(posedge clk); #1;
    vs2[0*ELEN +: ELEN] = 32'd5; vs2[1*ELEN +: ELEN] = 32'd0;
    vs2[2*ELEN +: ELEN] = 32'd0; vs2[3*ELEN +: ELEN] = 32'd7;
    run_op(OP_PASS, 4'd4, 8'b0000_0101, lat);
    tests++; if (lat != 5) begin fails++; $display("FAIL mask_latency got %0d want 5", lat); end
    tests++; if (el(vd, 0) !== 32'd5 || el(vd, 1) !== 32'd20 || el(vd, 2) !== 32'd0 || el(vd, 3) !== 32'd40) begin
      fails++; $display("FAIL mask_vd got %h %h %h %h want 5 14 0 28", el(vd, 0), el(vd, 1), el(vd, 2), el(vd, 3));
    end
    tests++; if (zero_mask[3:0] !== 4'b0100) begin fails++; $display("FAIL mask_zmask got %b want 0100", zero_mask[3:0]); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_vl_zero();
    test_sub_ignore_start();
    test_ovf_clear();
    test_clamp();
    test_reset_mid();
`ifdef VALU_MASK_EN
    test_mask();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
